// File: rtl/demux1to2_4bit_reg.sv
// demux1to2_4bit_reg: registered 1-to-2 demultiplexer with valid/ready on input
// and on both output channels. Select S steers each accepted word to channel 0 or 1.
// Each channel holds one word.
//
// Ports:
//   clk, rst_n          clock, async active-low reset
//   S, din, in_valid    input word, its channel select and valid
//   in_ready            combinational; depends on the selected channel only
//   y0/y0_valid/y0_ready  channel 0 output handshake
//   y1/y1_valid/y1_ready  channel 1 output handshake
//   cnt0, cnt1          per-channel accepted-word counters (DEMUX_CNT_EN only)
//
// Optional feature macro: DEMUX_CNT_EN adds the CNT_W parameter and the cnt0/cnt1
// ports. Counters wrap silently.
module demux1to2_4bit_reg #(
    parameter int unsigned W = 4
`ifdef DEMUX_CNT_EN
    , parameter int unsigned CNT_W = 8
`endif
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         S,
    input  logic [W-1:0] din,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [W-1:0] y0,
    output logic         y0_valid,
    input  logic         y0_ready,
    output logic [W-1:0] y1,
    output logic         y1_valid,
    input  logic         y1_ready
`ifdef DEMUX_CNT_EN
    , output logic [CNT_W-1:0] cnt0,
    output logic [CNT_W-1:0] cnt1
`endif
);

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} ch_state_t;

    ch_state_t    st0_q, st0_d, st1_q, st1_d;
    logic [W-1:0] y0_q, y0_d, y1_q, y1_d;
    logic         can_accept0, can_accept1;
    logic         push0, push1;

    // A full channel can still take a word in the same cycle it is being popped.
    assign can_accept0 = (st0_q == EMPTY) | y0_ready;
    assign can_accept1 = (st1_q == EMPTY) | y1_ready;
    assign in_ready    = rst_n & (S ? can_accept1 : can_accept0);
    assign push0       = in_valid & in_ready & ~S;
    assign push1       = in_valid & in_ready & S;

    assign y0       = y0_q;
    assign y1       = y1_q;
    assign y0_valid = (st0_q == FULL);
    assign y1_valid = (st1_q == FULL);

    // State registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st0_q <= EMPTY;
            st1_q <= EMPTY;
            y0_q  <= '0;
            y1_q  <= '0;
        end else begin
            st0_q <= st0_d;
            st1_q <= st1_d;
            y0_q  <= y0_d;
            y1_q  <= y1_d;
        end
    end

    // Channel 0 next state: push wins over pop so a pop+push keeps the channel full.
    always_comb begin
        st0_d = st0_q;
        y0_d  = y0_q;
        case (st0_q)
            EMPTY: begin
                if (push0) begin
                    st0_d = FULL;
                    y0_d  = din;
                end
            end
            FULL: begin
                if (push0) begin
                    y0_d = din;
                end else if (y0_ready) begin
                    st0_d = EMPTY;
                end
            end
            default: st0_d = EMPTY;
        endcase
    end

    // Channel 1 next state, same structure as channel 0.
    always_comb begin
        st1_d = st1_q;
        y1_d  = y1_q;
        case (st1_q)
            EMPTY: begin
                if (push1) begin
                    st1_d = FULL;
                    y1_d  = din;
                end
            end
            FULL: begin
                if (push1) begin
                    y1_d = din;
                end else if (y1_ready) begin
                    st1_d = EMPTY;
                end
            end
            default: st1_d = EMPTY;
        endcase
    end

`ifdef DEMUX_CNT_EN
    logic [CNT_W-1:0] cnt0_q, cnt0_d, cnt1_q, cnt1_d;

    // Accepted-word counters, wrapping at 2^CNT_W.
    always_comb begin
        cnt0_d = cnt0_q;
        cnt1_d = cnt1_q;
        if (push0) cnt0_d = cnt0_q + CNT_W'(1);
        if (push1) cnt1_d = cnt1_q + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt0_q <= '0;
            cnt1_q <= '0;
        end else begin
            cnt0_q <= cnt0_d;
            cnt1_q <= cnt1_d;
        end
    end

    assign cnt0 = cnt0_q;
    assign cnt1 = cnt1_q;
`endif

endmodule

// File: doc/demux1to2_4bit_reg.md
Name: demux1to2_4bit_reg

Overview:
- Registered 1-to-2 demultiplexer with valid/ready handshake on all three sides.
- It is the inverse of the 4-bit 2-to-1 mux. One input word stream is steered by select S to output channel 0 or channel 1.
- Each output channel has a one-entry holding register.
- Sits in front of paired consumers that were previously fed through a 2-to-1 mux.

Parameters:
- W, 4, data width of din, y0, y1.
- CNT_W, 8, width of the per-channel transfer counters. Only used when DEMUX_CNT_EN is defined.

Ports:
- clk  input  1  clock; all state updates on its rising edge.
- rst_n  input  1  asynchronous active-low reset.
- S  input  1  channel select, sampled with din when in_valid is high; 0 selects channel 0, 1 selects channel 1.
- din  input  W  input data word.
- in_valid  input  1  din/S are valid this cycle.
- in_ready  output  1  block accepts din this cycle.
- y0  output  W  channel 0 data.
- y0_valid  output  1  y0 holds a word.
- y0_ready  input  1  channel 0 consumer takes y0 this cycle.
- y1  output  W  channel 1 data.
- y1_valid  output  1  y1 holds a word.
- y1_ready  input  1  channel 1 consumer takes y1 this cycle.
- cnt0  output  CNT_W  channel 0 accepted-word count (DEMUX_CNT_EN only).
- cnt1  output  CNT_W  channel 1 accepted-word count (DEMUX_CNT_EN only).

Behaviour:
- Reset: async assert on rst_n low, sync-free release.
  - y0, y1 = 0; y0_valid, y1_valid = 0; cnt0, cnt1 = 0.
  - in_ready is combinational and is low while rst_n is low.
- Each channel k is a two-state register: EMPTY (yk_valid=0) or FULL (yk_valid=1).
- Readiness:
  - can_accept_k = !yk_valid | yk_ready.
  - in_ready = rst_n & (S ? can_accept_1 : can_accept_0).
  - in_ready depends only on the selected channel; the unselected channel never stalls input.
- Input transfer occurs when in_valid & in_ready. At the next edge the selected channel loads din into yk and sets yk_valid=1. The unselected channel is untouched.
- Output transfer occurs when yk_valid & yk_ready. At the next edge yk_valid clears unless a new input transfer targets channel k in the same cycle.
  - Simultaneous pop and push on the same channel: yk loads new din, yk_valid stays 1. This gives full throughput of one word per cycle per channel with no bubble.
- Latency: din accepted in cycle N is visible on yk with yk_valid=1 in cycle N+1.
- Holding stability:
  - While yk_valid=1 and yk_ready=0, yk must not change.
  - yk keeps its last value after being popped; data is don't-care when yk_valid=0 but must not glitch to X.
- Both channels can drain in the same cycle independently.
- yk_ready asserted while yk_valid=0 has no effect.
- S or din changing while in_valid=0: no effect.
- in_valid=1 with in_ready=0: no state change. The source must hold S/din; the block does not require it but only acts on the accepted cycle.
- Reset mid-operation: any held word is discarded, both channels return to EMPTY, and counters clear. No partial transfer survives.
- No combinational path from din to yk; yk_ready to in_ready is combinational.

Optional Feature:
- Macro: DEMUX_CNT_EN.
- Defined:
  - cnt0/cnt1 increment by 1 on each input transfer into channel 0/1 respectively.
  - Counters wrap from 2^CNT_W-1 to 0 silently.
  - Counters are reset to 0 by rst_n.
- Not defined: cnt0/cnt1 ports are absent and no counter logic is built. All other behaviour is identical.

Test Plan:
- Reset check: hold rst_n=0 with in_valid=1, S=0, din=4'hA. Required: in_ready=0, y0_valid=y1_valid=0, y0=y1=0. Release rst_n; the next cycle in_ready=1.
- Basic steering: push din=4'h5 with S=0, then din=4'hC with S=1, with y0_ready=y1_ready=1. Required: y0=4'h5 with y0_valid=1 one cycle after the first push; y1=4'hC with y1_valid=1 one cycle after the second push. Each valid pulses for exactly 1 cycle.
- Back-pressure: y0_ready=0, push 4'h3 to channel 0, then attempt 4'h7 to channel 0. Required: y0 holds 4'h3, in_ready=0 for S=0. A push of 4'h9 with S=1 is accepted onto y1 meanwhile. Raising y0_ready gives 4'h7 on y0 the following cycle.
- Full throughput: stream 8 words 4'h0..4'h7 to channel 1 on consecutive cycles with y1_ready=1 constantly. Required: in_ready stays 1 throughout; y1 shows 0..7 in consecutive cycles 1..8.
- Reset mid-operation: with both channels FULL (y0=4'h1, y1=4'h2, readies low), pulse rst_n low between clock edges. Required: y0_valid and y1_valid drop immediately. After release, neither held word reappears.
- DEMUX_CNT_EN with CNT_W=2: push 5 words to channel 0 and 1 word to channel 1. Required: cnt0 = 1 (wrapped), cnt1 = 1. After reset, both counters are 0.
